inst_encoder: RTL and testbench
===============================

# inst_encoder

RV32I instruction encoder: inverse of the instruction decoder. Accepts field-level encode requests (format type, opcode, funct3, funct7, register indices, immediate) over a valid/ready handshake. Range-checks each request, packs it into a 32-bit RV32I instruction word and queues it in a small FIFO. The FIFO feeds instruction memory preload logic and the decoder bench as a legal-instruction source.

## Interface
- DEPTH, 4, output FIFO entries; power of two, ≥2
- clk  in  1  system clock, all state on rising edge
- nrst  in  1  reset, asynchronous, active-low
- in_valid  in  1  encode request present
- in_ready  out  1  request accepted this cycle when in_valid & in_ready
- in_type  in  3  format: R=0, I=1, S=2, SB=3, UJ=4, U=5; 6,7 illegal
- in_opcode  in  7  opcode field
- in_funct3  in  3  funct3 field
- in_funct7  in  7  funct7 field (used by R only)
- in_rs1, in_rs2, in_rd  in  5 each  register indices
- in_imm  in  32  byte-offset / value immediate, two's complement
- out_valid  out  1  FIFO head holds an instruction
- out_ready  in  1  consumer takes head when out_valid & out_ready
- out_inst  out  32  encoded word at FIFO head; 32'h0 when empty
- out_type  out  3  format of head entry; 0 when empty
- level  out  $clog2(DEPTH)+1  entries in FIFO
- err_valid  out  1  one-cycle pulse: last accepted request rejected
- err_code  out  2  reason for last rejection, held until next rejection
- err_count  out  8  rejected requests, saturating at 255

## Operation
- in_ready = (level != DEPTH); independent of out_ready (no push into a full FIFO even with a simultaneous pop).
- Accepted request is checked. Checks are in priority order, and the first failure sets err_code:
  - 0: in_type > 5
  - 1: in_opcode[1:0] != 2'b11
  - 2: immediate out of range: I/S signed 12-bit; SB signed 13-bit; UJ signed 21-bit
  - 3: misaligned: SB/UJ with in_imm[0]=1; U with in_imm[11:0] != 0
- R never fails checks 2/3. Unused fields for a format are ignored.
- Rejected request:
  - nothing written to the FIFO
  - err_valid=1 next cycle, err_code updated
  - err_count += 1 unless already 255
- Legal request: packed word written at the FIFO tail together with in_type:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - SB: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - UJ: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
  - U: {imm[31:12], rd, opcode}
- FIFO:
  - circular buffer, read/write pointers wrap modulo DEPTH
  - simultaneous push and pop with 0 < level < DEPTH leaves level unchanged
  - pop with level 0 is ignored

## Timing
- Reset values (async, immediate on nrst low):
  - level=0, pointers=0, out_valid=0, out_inst=0, out_type=0
  - err_valid=0, err_code=0, err_count=0
  - in_ready=1 once nrst is high
- Latency: request accepted at edge N → out_valid=1 and out_inst valid after edge N (cycle N+1) if FIFO was empty; otherwise in FIFO order.
- err_valid asserted exactly one cycle after the accepting edge, then deasserts unless another rejection is accepted.
- Reset mid-operation discards all queued entries and error state; no partial entry survives.
- out_inst/out_type combinational from head entry; stable while out_valid & !out_ready.

## Test plan
- R add x3,x1,x2 (type 0, opcode 0x33, funct3 0, funct7 0, rd 3, rs1 1, rs2 2) → out_inst 0x002081B3 one cycle later, out_type 0, level 1.
- I addi x5,x0,-1 (opcode 0x13, imm 0xFFFFFFFF) → 0xFFF00293. Same with imm 2048 → err_valid pulse, err_code 2, level unchanged.
- SB beq x1,x2,+8 (opcode 0x63) → 0x00208463. imm 7 → err_code 3. UJ jal x1,+2048 (opcode 0x6F, rd 1) → 0x001000EF.
- Priority: type 7 with opcode 0x00 → err_code 0. Type 1 with opcode 0x10 → err_code 1. Inject 300 rejects → err_count 255.
- DEPTH=4, out_ready=0, push 5 legal requests → in_ready low after 4th, level 4, 5th held. Then out_ready=1 for 4 cycles → words pop in order, level 0, out_inst 0. Verify wrap on a second pass.
- Fill to level 2, pulse nrst low mid-cycle → level 0, out_valid 0, err_count 0 immediately. First post-reset request emerges correctly.

Source files
------------

// File: rtl/inst_encoder.sv
// RV32I instruction encoder. Range-checks field-level encode requests,
// packs legal ones into 32-bit instruction words and queues them in a
// small circular FIFO together with their format type. Rejected requests
// produce a one-cycle error pulse, a sticky reason code and a saturating
// reject counter.
//
// Handshake: a transfer happens on a rising edge where valid & ready are
// both high. On the input side, ready depends only on FIFO occupancy (never
// on valid or out_ready). On the output side, valid depends only on
// occupancy. The head word stays stable while valid & !ready.
module inst_encoder #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_type,
  input  logic [6:0]                 in_opcode,
  input  logic [2:0]                 in_funct3,
  input  logic [6:0]                 in_funct7,
  input  logic [4:0]                 in_rs1,
  input  logic [4:0]                 in_rs2,
  input  logic [4:0]                 in_rd,
  input  logic [31:0]                in_imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_inst,
  output logic [2:0]                 out_type,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       err_valid,
  output logic [1:0]                 err_code,
  output logic [7:0]                 err_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  localparam logic [2:0] T_R  = 3'd0;
  localparam logic [2:0] T_I  = 3'd1;
  localparam logic [2:0] T_S  = 3'd2;
  localparam logic [2:0] T_SB = 3'd3;
  localparam logic [2:0] T_UJ = 3'd4;
  localparam logic [2:0] T_U  = 3'd5;

  // FIFO storage and bookkeeping
  logic [31:0]   inst_q [DEPTH];
  logic [2:0]    type_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  // Error reporting state
  logic          err_valid_q, err_valid_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [7:0]    err_count_q, err_count_d;

  // Check / pack results for the current request
  logic          reject;
  logic [1:0]    reject_code;
  logic [31:0]   packed_word;
  logic          fits12, fits13, fits21;

  logic          accept, push, pop;

  // A signed N-bit value fits when every bit from N-1 upward matches.
  assign fits12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign fits13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign fits21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  assign in_ready  = (level_q != LW'(DEPTH));
  assign out_valid = (level_q != '0);
  assign accept    = in_valid & in_ready;
  assign push      = accept & ~reject;
  assign pop       = out_valid & out_ready;

  // Ordered legality checks; the first failing check names the reason.
  always_comb begin
    reject      = 1'b0;
    reject_code = 2'd0;
    if (in_type > T_U) begin
      reject      = 1'b1;
      reject_code = 2'd0;
    end else if (in_opcode[1:0] != 2'b11) begin
      reject      = 1'b1;
      reject_code = 2'd1;
    end else begin
      case (in_type)
        T_I, T_S: begin
          if (!fits12) begin
            reject      = 1'b1;
            reject_code = 2'd2;
          end
        end
        T_SB: begin
          if (!fits13) begin
            reject      = 1'b1;
            reject_code = 2'd2;
          end else if (in_imm[0]) begin
            reject      = 1'b1;
            reject_code = 2'd3;
          end
        end
        T_UJ: begin
          if (!fits21) begin
            reject      = 1'b1;
            reject_code = 2'd2;
          end else if (in_imm[0]) begin
            reject      = 1'b1;
            reject_code = 2'd3;
          end
        end
        T_U: begin
          if (in_imm[11:0] != 12'd0) begin
            reject      = 1'b1;
            reject_code = 2'd3;
          end
        end
        default: begin
          reject      = 1'b0;
          reject_code = 2'd0;
        end
      endcase
    end
  end

  // Pack the request fields into the RV32I word for its format.
  always_comb begin
    packed_word = 32'h0;
    case (in_type)
      T_R:  packed_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      T_I:  packed_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      T_S:  packed_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      T_SB: packed_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], in_opcode};
      T_UJ: packed_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                           in_rd, in_opcode};
      T_U:  packed_word = {in_imm[31:12], in_rd, in_opcode};
      default: packed_word = 32'h0;
    endcase
  end

  // Next-state for pointers, occupancy and error reporting.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    err_valid_d = accept & reject;
    err_code_d  = err_code_q;
    err_count_d = err_count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (accept && reject) begin
      err_code_d = reject_code;
      if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end
  end

  // Control registers; reset empties the queue and clears error state.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= 2'd0;
      err_count_q <= 8'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      err_count_q <= err_count_d;
    end
  end

  // FIFO storage; entries are cleared on reset so nothing stale survives.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= 32'h0;
        type_q[i] <= 3'd0;
      end
    end else if (push) begin
      inst_q[wr_ptr_q] <= packed_word;
      type_q[wr_ptr_q] <= in_type;
    end
  end

  assign out_inst  = out_valid ? inst_q[rd_ptr_q] : 32'h0;
  assign out_type  = out_valid ? type_q[rd_ptr_q] : 3'd0;
  assign level     = level_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed testbench for inst_encoder: packing per format, error priority
// and saturation, FIFO full/wrap ordering and asynchronous reset.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        nrst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_type;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [2:0]  out_type;
  logic [2:0]  level;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] addi_w [1:5];

  always #5 clk = ~clk;

  inst_encoder #(.DEPTH(4)) dut (
    .clk(clk), .nrst(nrst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_opcode(in_opcode), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_type(out_type), .level(level),
    .err_valid(err_valid), .err_code(err_code), .err_count(err_count)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] t, input logic [6:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] rd, input logic [31:0] imm);
    in_type = t; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_imm = imm;
    in_valid = 1'b1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // addi xk, x0, k
  task automatic push_addi(input int k);
    req(3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'(k), 32'(k));
    cyc();
    idle();
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_type = '0; in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_imm = '0;
    #12;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", level); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL rst_out_inst got %h exp 0", out_inst); end
    checks++; if (out_type !== 3'd0) begin errors++; $display("FAIL rst_out_type got %0d exp 0", out_type); end
    checks++; if (err_valid !== 1'b0 || err_code !== 2'd0 || err_count !== 8'd0) begin
      errors++; $display("FAIL rst_err got %b/%0d/%0d exp 0/0/0", err_valid, err_code, err_count); end
    @(negedge clk);
    nrst = 1'b1;
    cyc();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_r_type();
    req(3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'h0);
    cyc(); idle();
    checks++; if (out_inst !== 32'h002081B3) begin errors++; $display("FAIL r_add got %h exp 002081b3", out_inst); end
    checks++; if (out_type !== 3'd0) begin errors++; $display("FAIL r_type got %0d exp 0", out_type); end
    checks++; if (level !== 3'd1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL r_level got %0d/%b exp 1/1", level, out_valid); end
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL r_err_valid got %b exp 0", err_valid); end
    pop_one();
    checks++; if (level !== 3'd0 || out_inst !== 32'h0) begin
      errors++; $display("FAIL r_pop got %0d/%h exp 0/0", level, out_inst); end
  endtask

  task automatic test_i_s_type();
    req(3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'hFFFF_FFFF);
    cyc(); idle();
    checks++; if (out_inst !== 32'hFFF00293) begin errors++; $display("FAIL i_addi got %h exp fff00293", out_inst); end
    checks++; if (out_type !== 3'd1) begin errors++; $display("FAIL i_type got %0d exp 1", out_type); end
    pop_one();
    req(3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'd2048);
    cyc(); idle();
    checks++; if (err_valid !== 1'b1) begin errors++; $display("FAIL i_range_pulse got %b exp 1", err_valid); end
    checks++; if (err_code !== 2'd2) begin errors++; $display("FAIL i_range_code got %0d exp 2", err_code); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL i_range_level got %0d exp 0", level); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL i_range_count got %0d exp 1", err_count); end
    cyc();
    checks++; if (err_valid !== 1'b0 || err_code !== 2'd2) begin
      errors++; $display("FAIL i_pulse_end got %b/%0d exp 0/2", err_valid, err_code); end
    // sw x2, 4(x1)
    req(3'd2, 7'h23, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 32'd4);
    cyc(); idle();
    checks++; if (out_inst !== 32'h0020A223) begin errors++; $display("FAIL s_sw got %h exp 0020a223", out_inst); end
    pop_one();
  endtask

  task automatic test_sb_uj_u();
    req(3'd3, 7'h63, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8);
    cyc(); idle();
    checks++; if (out_inst !== 32'h00208463 || out_type !== 3'd3) begin
      errors++; $display("FAIL sb_beq got %h/%0d exp 00208463/3", out_inst, out_type); end
    pop_one();
    req(3'd3, 7'h63, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd7);
    cyc(); idle();
    checks++; if (err_valid !== 1'b1 || err_code !== 2'd3) begin
      errors++; $display("FAIL sb_misalign got %b/%0d exp 1/3", err_valid, err_code); end
    req(3'd4, 7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd2048);
    cyc(); idle();
    checks++; if (out_inst !== 32'h001000EF || out_type !== 3'd4) begin
      errors++; $display("FAIL uj_jal got %h/%0d exp 001000ef/4", out_inst, out_type); end
    pop_one();
    // lui x5, 0x12345
    req(3'd5, 7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'h1234_5000);
    cyc(); idle();
    checks++; if (out_inst !== 32'h123452B7 || out_type !== 3'd5) begin
      errors++; $display("FAIL u_lui got %h/%0d exp 123452b7/5", out_inst, out_type); end
    pop_one();
    req(3'd5, 7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'h1234_5001);
    cyc(); idle();
    checks++; if (err_code !== 2'd3 || level !== 3'd0) begin
      errors++; $display("FAIL u_misalign got %0d/%0d exp 3/0", err_code, level); end
    checks++; if (err_count !== 8'd3) begin errors++; $display("FAIL u_count got %0d exp 3", err_count); end
  endtask

  task automatic test_priority();
    req(3'd7, 7'h00, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd1);
    cyc(); idle();
    checks++; if (err_code !== 2'd0 || err_valid !== 1'b1) begin
      errors++; $display("FAIL prio_type got %0d/%b exp 0/1", err_code, err_valid); end
    req(3'd1, 7'h10, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd4096);
    cyc(); idle();
    checks++; if (err_code !== 2'd1) begin errors++; $display("FAIL prio_opcode got %0d exp 1", err_code); end
    checks++; if (err_count !== 8'd5) begin errors++; $display("FAIL prio_count got %0d exp 5", err_count); end
    req(3'd7, 7'h33, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    for (int i = 0; i < 300; i++) cyc();
    checks++; if (err_valid !== 1'b1) begin errors++; $display("FAIL sat_pulse got %b exp 1", err_valid); end
    idle();
    cyc();
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_count got %0d exp 255", err_count); end
    checks++; if (err_valid !== 1'b0 || err_code !== 2'd0) begin
      errors++; $display("FAIL sat_end got %b/%0d exp 0/0", err_valid, err_code); end
  endtask

  task automatic test_fifo_full_wrap();
    logic [31:0] head;
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d got %b exp 1", k, in_ready); end
      push_addi(k);
      exp_q.push_back(addi_w[k]);
    end
    checks++; if (level !== 3'd4 || in_ready !== 1'b0) begin
      errors++; $display("FAIL full got %0d/%b exp 4/0", level, in_ready); end
    push_addi(5);
    checks++; if (level !== 3'd4 || out_inst !== addi_w[1]) begin
      errors++; $display("FAIL full_held got %0d/%h exp 4/%h", level, out_inst, addi_w[1]); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      head = exp_q.pop_front();
      checks++; if (out_inst !== head) begin errors++; $display("FAIL drain%0d got %h exp %h", i, out_inst, head); end
      cyc();
    end
    out_ready = 1'b0;
    checks++; if (level !== 3'd0 || out_valid !== 1'b0 || out_inst !== 32'h0) begin
      errors++; $display("FAIL drained got %0d/%b/%h exp 0/0/0", level, out_valid, out_inst); end
    // second pass: pointers wrap and a simultaneous push/pop holds level
    push_addi(5); exp_q.push_back(addi_w[5]);
    push_addi(2); exp_q.push_back(addi_w[2]);
    push_addi(3); exp_q.push_back(addi_w[3]);
    head = exp_q.pop_front();
    checks++; if (out_inst !== head) begin errors++; $display("FAIL wrap_head got %h exp %h", out_inst, head); end
    out_ready = 1'b1;
    push_addi(4); exp_q.push_back(addi_w[4]);
    out_ready = 1'b0;
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL pushpop_level got %0d exp 3", level); end
    push_addi(1); exp_q.push_back(addi_w[1]);
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL wrap_full got %0d exp 4", level); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      head = exp_q.pop_front();
      checks++; if (out_inst !== head) begin errors++; $display("FAIL wrap_drain%0d got %h exp %h", i, out_inst, head); end
      cyc();
    end
    out_ready = 1'b0;
    checks++; if (level !== 3'd0 || out_inst !== 32'h0) begin
      errors++; $display("FAIL wrap_empty got %0d/%h exp 0/0", level, out_inst); end
    // pop on empty is ignored
    pop_one();
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL empty_pop got %0d exp 0", level); end
  endtask

  task automatic test_reset_mid();
    push_addi(1);
    push_addi(2);
    req(3'd1, 7'h10, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    cyc(); idle();
    checks++; if (level !== 3'd2 || err_code !== 2'd1) begin
      errors++; $display("FAIL pre_rst got %0d/%0d exp 2/1", level, err_code); end
    @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    checks++; if (level !== 3'd0 || out_valid !== 1'b0 || out_inst !== 32'h0) begin
      errors++; $display("FAIL mid_rst_fifo got %0d/%b/%h exp 0/0/0", level, out_valid, out_inst); end
    checks++; if (err_count !== 8'd0 || err_code !== 2'd0 || err_valid !== 1'b0) begin
      errors++; $display("FAIL mid_rst_err got %0d/%0d/%b exp 0/0/0", err_count, err_code, err_valid); end
    #3 nrst = 1'b1;
    cyc();
    req(3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'h0);
    cyc(); idle();
    checks++; if (out_inst !== 32'h002081B3 || level !== 3'd1) begin
      errors++; $display("FAIL post_rst got %h/%0d exp 002081b3/1", out_inst, level); end
    pop_one();
  endtask

  initial begin
    addi_w[1] = 32'h00100093;
    addi_w[2] = 32'h00200113;
    addi_w[3] = 32'h00300193;
    addi_w[4] = 32'h00400213;
    addi_w[5] = 32'h00500293;
    test_reset();
    test_r_type();
    test_i_s_type();
    test_sb_uj_u();
    test_priority();
    test_fifo_full_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
